fdtd_ez_update_pipe: RTL and testbench
======================================

Name: fdtd_ez_update_pipe

Overview:
- Streaming, parametrised Ez field-update engine for the FDTD accelerator in the user plugin.
- Computes Ez_new = ceze*Ez_old + cezhy*(Hy[i] - Hy[i-1]) in signed fixed point, one cell per beat.
- Uses a valid/ready handshake with backpressure, row-boundary handling, PEC cell masking, rounding and overflow control.
- Sits between the field-memory read sequencer and the Ez write-back path.

Parameters:
- DATA_W, 32, width of field samples and coefficients (signed two's complement).
- FRAC_W, 30, fractional bits of the coefficients; product scale-back shift. Legal range 1..DATA_W-1.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- clr  in  1  synchronous pipeline flush.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_first  in  1  beat is the first cell of a row.
- s_last  in  1  beat is the last cell of a row; passed through to m_last.
- s_pec  in  1  cell is a PEC cell; the result is forced to 0.
- s_hy  in  DATA_W  Hy[i].
- s_ez_old  in  DATA_W  Ez[i] from the previous time step.
- s_cezhy  in  DATA_W  per-cell curl coefficient.
- s_ceze  in  DATA_W  per-cell decay coefficient.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_ez  out  DATA_W  updated Ez[i].
- m_last  out  1  delayed s_last.
- sat_cnt  out  CNT_W  count of saturation events.

Behaviour:
- Reset (RST_N low, asynchronous):
  - m_valid=0, m_ez=0, m_last=0, sat_cnt=0.
  - All stage valids=0; hy_prev=0.
  - s_ready=1 after reset.
- Pipeline structure:
  - 4 register stages; one global advance: adv = m_ready || !m_valid; s_ready = adv.
  - When adv=0, every stage holds, and m_ez/m_last stay stable.
  - Internal bubbles are not collapsed.
- Latency: a beat accepted at edge N appears with m_valid=1 after edge N+4, provided adv stays 1 throughout. Throughput is 1 beat/cycle.
- S1 (difference):
  - diff = s_hy - (s_first ? 0 : hy_prev), DATA_W+1 bits, sign-extended.
  - hy_prev <= s_hy on every accepted beat, PEC beats included.
  - ez_old, the coefficients, pec and last are registered alongside diff.
- S2 (multiply):
  - p0 = diff*cezhy, 2*DATA_W+1 bits.
  - p1 = ez_old*ceze, 2*DATA_W bits.
  - Both are full precision and signed.
- S3 (sum): sum = p0 + p1, 2*DATA_W+2 bits. No loss.
- S4 (round and scale):
  - r = (sum + 2^(FRAC_W-1)) >>> FRAC_W, i.e. round half toward +inf.
  - r is then reduced to DATA_W bits (see Optional Feature).
  - If pec=1, m_ez=0 and the beat does not count as a saturation event.
- clr:
  - Clears all stage valids, m_valid and hy_prev in the same cycle.
  - Has priority over simultaneous handshakes; the beat offered that cycle is dropped.
  - sat_cnt is unaffected.
- s_first and s_last may both be 1 on the same beat (single-cell row).
- A row boundary without s_first does not reset hy_prev; the upstream sequencer must mark row starts.
- RST_N asserted mid-stream: all in-flight beats are lost, with no partial output.

Optional Feature:
- Macro: FDTD_EZ_SAT_EN.
- Defined:
  - r outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] clamps to the nearest bound.
  - Each clamped beat, when it leaves S4 into the output register, increments sat_cnt.
  - sat_cnt sticks at all-ones and does not wrap.
- Undefined:
  - m_ez = r[DATA_W-1:0] (two's-complement wrap).
  - sat_cnt is constant 0; the port remains present.

Decomposition:
- Shared package fdtd_pkg:
  - Localparams for product/sum widths derived from DATA_W.
  - Typedef of the per-stage sideband struct {valid, pec, last}.
  - Function fx_round_shift.
- Sub-module fdtd_fx_round_sat: the combinational S4 round/shift/clamp plus saturation flag, parametrised by DATA_W/FRAC_W. Reused later by the Hy update engine.

Test Plan (defaults; 1.0 = 0x4000_0000, 0.5 = 0x2000_0000):
- First cell, hy=100, ez_old=0, cezhy=ceze=1.0; next beat hy=40, ez_old=10 -> m_ez=100, then -50 (diff -60); each appears 4 cycles after acceptance.
- Rounding, cezhy=0, ceze=0.5: ez_old=3 -> 2; ez_old=-3 -> -1; ez_old=1 -> 1.
- Saturation, ez_old=0x7FFF_FFFF, ceze=1.0, diff=+1, cezhy=1.0:
  - With FDTD_EZ_SAT_EN: m_ez=0x7FFF_FFFF, sat_cnt 0->1.
  - Without: m_ez=0x8000_0000, sat_cnt=0.
- Backpressure: stream 8 beats, m_ready low 3 cycles mid-stream -> s_ready low those cycles, m_ez stable, all 8 results in order, none lost or duplicated.
- PEC/boundary: s_pec=1 on a cell with hy=7 -> m_ez=0; next cell hy=9, cezhy=1.0, ez_old=0 -> m_ez=2. Then a new row with s_first, hy=5 -> 5.
- clr asserted with 3 beats in flight -> m_valid stays 0, next accepted first-cell beat produces the correct result.

Source files
------------

// File: rtl/fdtd_pkg.sv
// Shared widths, per-stage sideband type and fixed-point rounding helper for the FDTD update engines.
package fdtd_pkg;

    // Widest intermediate the rounding helper accepts; covers 2*DATA_W+2 for DATA_W up to 78.
    localparam int FX_MAX_W = 160;

    // Default-width figures for the standard 32-bit field format.
    localparam int FDTD_DATA_W = 32;
    localparam int FDTD_SUM_W  = 2 * FDTD_DATA_W + 2;

    function automatic int diff_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int p0_w(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int p1_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int sum_w(input int dw);
        return 2 * dw + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic pec;
        logic last;
    } sb_t;

    // Round half toward +inf, then arithmetic shift right by sh (sh >= 1).
    function automatic logic signed [FX_MAX_W-1:0] fx_round_shift(
        input logic signed [FX_MAX_W-1:0] x,
        input int                         sh
    );
        logic signed [FX_MAX_W-1:0] half;
        half = {{(FX_MAX_W-1){1'b0}}, 1'b1} << (sh - 1);
        return (x + half) >>> sh;
    endfunction

endpackage

// File: rtl/fdtd_fx_round_sat.sv
// Combinational round-half-up and scale-back by FRAC_W, reduced to DATA_W bits.
// With FDTD_EZ_SAT_EN defined the result clamps and flags sat; otherwise it wraps and sat is 0.
module fdtd_fx_round_sat
    import fdtd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 30,
    parameter int SUM_W  = 2 * DATA_W + 2
) (
    input  logic signed [SUM_W-1:0]  sum,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

`ifdef FDTD_EZ_SAT_EN
    localparam logic signed [FX_MAX_W-1:0] MAX_POS =
        {{(FX_MAX_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [FX_MAX_W-1:0] MIN_NEG =
        {{(FX_MAX_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [FX_MAX_W-1:0] r;

    always_comb begin
        r   = fx_round_shift(FX_MAX_W'(sum), FRAC_W);
        y   = DATA_W'(r);
        sat = 1'b0;
        if (r > MAX_POS) begin
            y   = DATA_W'(MAX_POS);
            sat = 1'b1;
        end else if (r < MIN_NEG) begin
            y   = DATA_W'(MIN_NEG);
            sat = 1'b1;
        end
    end
`else
    always_comb begin
        y   = DATA_W'(fx_round_shift(FX_MAX_W'(sum), FRAC_W));
        sat = 1'b0;
    end
`endif

endmodule

// File: rtl/fdtd_ez_update_pipe.sv
// Streaming Ez update: Ez' = ceze*Ez + cezhy*(Hy[i]-Hy[i-1]); 4 register stages then the output register.
// Range reduction saturates when FDTD_EZ_SAT_EN is defined, otherwise wraps (sat_cnt then stays 0).
module fdtd_ez_update_pipe
    import fdtd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 30,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     clr,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_first,
    input  logic                     s_last,
    input  logic                     s_pec,
    input  logic signed [DATA_W-1:0] s_hy,
    input  logic signed [DATA_W-1:0] s_ez_old,
    input  logic signed [DATA_W-1:0] s_cezhy,
    input  logic signed [DATA_W-1:0] s_ceze,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_ez,
    output logic                     m_last,
    output logic [CNT_W-1:0]         sat_cnt
);

    localparam int DIFF_W = diff_w(DATA_W);
    localparam int P0_W   = p0_w(DATA_W);
    localparam int P1_W   = p1_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W);

    logic adv;

    sb_t sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d, sb4_q, sb4_d;

    logic signed [DIFF_W-1:0] diff1_q, diff1_d;
    logic signed [DATA_W-1:0] ez1_q, ez1_d, cezhy1_q, cezhy1_d, ceze1_q, ceze1_d;
    logic signed [P0_W-1:0]   p0_2_q, p0_2_d;
    logic signed [P1_W-1:0]   p1_2_q, p1_2_d;
    logic signed [SUM_W-1:0]  sum3_q, sum3_d;
    logic signed [DATA_W-1:0] y4_q, y4_d;
    logic                     sat4_q, sat4_d;

    logic signed [DATA_W-1:0] hy_prev_q, hy_prev_d, hy_base;
    logic signed [DATA_W-1:0] m_ez_q, m_ez_d;
    logic                     m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [CNT_W-1:0]         sat_cnt_q, sat_cnt_d;

    logic signed [DATA_W-1:0] y_rs;
    logic                     sat_rs;

    // One global enable: every stage moves only when the output slot is free or being taken.
    assign adv     = m_ready || !m_valid_q;
    assign s_ready = adv;
    assign m_valid = m_valid_q;
    assign m_ez    = m_ez_q;
    assign m_last  = m_last_q;
    assign sat_cnt = sat_cnt_q;

    fdtd_fx_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SUM_W  (SUM_W)
    ) u_round_sat (
        .sum (sum3_q),
        .y   (y_rs),
        .sat (sat_rs)
    );

    always_comb begin
        sb1_d     = sb1_q;
        sb2_d     = sb2_q;
        sb3_d     = sb3_q;
        sb4_d     = sb4_q;
        diff1_d   = diff1_q;
        ez1_d     = ez1_q;
        cezhy1_d  = cezhy1_q;
        ceze1_d   = ceze1_q;
        p0_2_d    = p0_2_q;
        p1_2_d    = p1_2_q;
        sum3_d    = sum3_q;
        y4_d      = y4_q;
        sat4_d    = sat4_q;
        hy_prev_d = hy_prev_q;
        m_valid_d = m_valid_q;
        m_ez_d    = m_ez_q;
        m_last_d  = m_last_q;
        sat_cnt_d = sat_cnt_q;
        hy_base   = s_first ? '0 : hy_prev_q;

        if (adv) begin
            // S1: spatial difference of Hy
            sb1_d.valid = s_valid;
            sb1_d.pec   = s_pec;
            sb1_d.last  = s_last;
            diff1_d     = DIFF_W'(s_hy) - DIFF_W'(hy_base);
            ez1_d       = s_ez_old;
            cezhy1_d    = s_cezhy;
            ceze1_d     = s_ceze;
            if (s_valid) begin
                hy_prev_d = s_hy;
            end
            // S2: full-precision products
            sb2_d  = sb1_q;
            p0_2_d = P0_W'(diff1_q) * P0_W'(cezhy1_q);
            p1_2_d = P1_W'(ez1_q) * P1_W'(ceze1_q);
            // S3: lossless sum
            sb3_d  = sb2_q;
            sum3_d = SUM_W'(p0_2_q) + SUM_W'(p1_2_q);
            // S4: rounded and range-reduced result
            sb4_d  = sb3_q;
            y4_d   = y_rs;
            sat4_d = sat_rs;
            // Output register; a masked PEC cell never counts as a saturation event.
            m_valid_d = sb4_q.valid;
            if (sb4_q.valid) begin
                m_ez_d   = sb4_q.pec ? '0 : y4_q;
                m_last_d = sb4_q.last;
                if (sat4_q && !sb4_q.pec && (sat_cnt_q != '1)) begin
                    sat_cnt_d = sat_cnt_q + CNT_W'(1);
                end
            end
        end

        // Flush wins over any handshake this cycle; the offered beat is dropped.
        if (clr) begin
            sb1_d.valid = 1'b0;
            sb2_d.valid = 1'b0;
            sb3_d.valid = 1'b0;
            sb4_d.valid = 1'b0;
            m_valid_d   = 1'b0;
            m_ez_d      = m_ez_q;
            m_last_d    = m_last_q;
            hy_prev_d   = '0;
            sat_cnt_d   = sat_cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sb1_q     <= '0;
            sb2_q     <= '0;
            sb3_q     <= '0;
            sb4_q     <= '0;
            hy_prev_q <= '0;
            m_valid_q <= 1'b0;
            m_ez_q    <= '0;
            m_last_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sb1_q     <= sb1_d;
            sb2_q     <= sb2_d;
            sb3_q     <= sb3_d;
            sb4_q     <= sb4_d;
            hy_prev_q <= hy_prev_d;
            m_valid_q <= m_valid_d;
            m_ez_q    <= m_ez_d;
            m_last_q  <= m_last_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Datapath registers carry no reset; their stage valid qualifies them.
    always_ff @(posedge CLK) begin
        diff1_q  <= diff1_d;
        ez1_q    <= ez1_d;
        cezhy1_q <= cezhy1_d;
        ceze1_q  <= ceze1_d;
        p0_2_q   <= p0_2_d;
        p1_2_q   <= p1_2_d;
        sum3_q   <= sum3_d;
        y4_q     <= y4_d;
        sat4_q   <= sat4_d;
    end

endmodule

// File: tb/tb_fdtd_ez_update_pipe.sv
// Self-checking bench for fdtd_ez_update_pipe: vector table plus backpressure, clr and reset sequences.
`timescale 1ns/1ps
module tb_fdtd_ez_update_pipe;

    localparam logic signed [31:0] ONE  = 32'sh4000_0000;
    localparam logic signed [31:0] HALF = 32'sh2000_0000;
`ifdef FDTD_EZ_SAT_EN
    localparam logic signed [31:0] EXP_SAT_EZ  = 32'sh7FFF_FFFF;
    localparam int                 EXP_SAT_CNT = 1;
`else
    localparam logic signed [31:0] EXP_SAT_EZ  = 32'sh8000_0000;
    localparam int                 EXP_SAT_CNT = 0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic clr = 1'b0;
    logic s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, s_pec = 1'b0;
    logic m_ready = 1'b1;
    logic signed [31:0] s_hy = '0, s_ez_old = '0, s_cezhy = '0, s_ceze = '0;
    logic s_ready, m_valid, m_last;
    logic signed [31:0] m_ez;
    logic [15:0] sat_cnt;

    fdtd_ez_update_pipe #(.DATA_W(32), .FRAC_W(30), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first), .s_last(s_last), .s_pec(s_pec),
        .s_hy(s_hy), .s_ez_old(s_ez_old), .s_cezhy(s_cezhy), .s_ceze(s_ceze),
        .m_valid(m_valid), .m_ready(m_ready), .m_ez(m_ez), .m_last(m_last), .sat_cnt(sat_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic first, last, pec;
        logic signed [31:0] hy, ez, cezhy, ceze, exp_ez;
    } vec_t;

    typedef struct {
        logic signed [31:0] ez;
        logic last;
        int acc_cyc;
        bit chk_lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0, failures = 0, cyc = 0, hold_cycles = 0;
    bit hold_prev = 0;
    logic signed [31:0] held_ez;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic l, input logic p,
                                input logic signed [31:0] hy, input logic signed [31:0] ez,
                                input logic signed [31:0] cz, input logic signed [31:0] ce,
                                input logic signed [31:0] ex);
        vec_t v;
        v.first = f; v.last = l; v.pec = p;
        v.hy = hy; v.ez = ez; v.cezhy = cz; v.ceze = ce; v.exp_ez = ex;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input bit push, input bit lat);
        int n;
        bit acc;
        exp_t e;
        s_valid = 1'b1; s_first = v.first; s_last = v.last; s_pec = v.pec;
        s_hy = v.hy; s_ez_old = v.ez; s_cezhy = v.cezhy; s_ceze = v.ceze;
        n = 0; acc = 0;
        while (!acc && n < 200) begin
            @(negedge CLK);
            acc = s_ready;
            @(posedge CLK);
            #1;
            n++;
        end
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_pec = 1'b0;
        check("send_accept", {63'b0, acc}, 64'd1);
        if (acc && push) begin
            e.ez = v.exp_ez; e.last = v.last; e.acc_cyc = cyc; e.chk_lat = lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check(name, sb_q.size(), 64'd0);
    endtask

    // Scoreboard monitor and backpressure stability, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", {63'b0, m_valid}, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("m_ez", m_ez, mon_e.ez);
                    check("m_last", {63'b0, m_last}, {63'b0, mon_e.last});
                    if (mon_e.chk_lat) check("latency", cyc, mon_e.acc_cyc + 4);
                end
            end
            if (m_valid && !m_ready) begin
                check("s_ready_bp", {63'b0, s_ready}, 64'd0);
                if (hold_prev) check("m_ez_hold", m_ez, held_ez);
                held_ez   = m_ez;
                hold_prev = 1;
                hold_cycles++;
            end else begin
                hold_prev = 0;
            end
        end else begin
            hold_prev = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = mk(1, 0, 0, 100, 0, ONE, ONE, 100);
        vecs[1] = mk(0, 1, 0, 40, 10, ONE, ONE, -50);
        vecs[2] = mk(1, 0, 0, 0, 3, 0, HALF, 2);
        vecs[3] = mk(0, 0, 0, 0, -3, 0, HALF, -1);
        vecs[4] = mk(0, 0, 0, 0, 1, 0, HALF, 1);
        vecs[5] = mk(1, 0, 0, 1, 32'sh7FFF_FFFF, ONE, ONE, EXP_SAT_EZ);
        vecs[6] = mk(0, 0, 1, 7, 123, ONE, ONE, 0);
        vecs[7] = mk(0, 1, 0, 9, 0, ONE, ONE, 2);
        vecs[8] = mk(1, 1, 0, 5, 0, ONE, ONE, 5);

        repeat (3) @(posedge CLK);
        #1;
        check("rst_m_valid", {63'b0, m_valid}, 64'd0);
        check("rst_m_ez", m_ez, 64'd0);
        check("rst_m_last", {63'b0, m_last}, 64'd0);
        check("rst_sat_cnt", sat_cnt, 64'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_s_ready", {63'b0, s_ready}, 64'd1);

        for (int i = 0; i < 9; i++) send(vecs[i], 1, 1);
        drain("drain_table");
        check("sat_cnt", sat_cnt, EXP_SAT_CNT);

        // Backpressure: m_ready low for 3 cycles while the stream is flowing.
        hold_cycles = 0;
        fork
            begin
                vec_t v;
                for (int i = 0; i < 8; i++) begin
                    v = mk(i == 0, i == 7, 0, 3 * i * i + 1, 2 * i, ONE, HALF,
                           (i == 0 ? 1 : 3 * (2 * i - 1)) + i);
                    send(v, 1, 0);
                end
            end
            begin
                repeat (6) @(posedge CLK);
                #1;
                m_ready = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                m_ready = 1'b1;
            end
        join
        drain("drain_bp");
        check("bp_hold_cycles", hold_cycles, 64'd3);

        // clr with 3 beats in flight and a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) send(mk(i == 0, 0, 0, 200 + i, 0, ONE, 0, 0), 0, 0);
        clr = 1'b1; s_valid = 1'b1; s_hy = 555; s_first = 1'b0;
        @(posedge CLK);
        #1;
        clr = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("clr_m_valid", {63'b0, m_valid}, 64'd0);
        end
        @(posedge CLK);
        #1;
        send(mk(0, 0, 0, 77, 0, ONE, 0, 77), 1, 1);
        send(mk(1, 1, 0, 30, 5, ONE, HALF, 33), 1, 1);
        drain("drain_clr");

        // Asynchronous reset with beats in flight.
        send(mk(1, 0, 0, 11, 0, ONE, 0, 11), 0, 0);
        send(mk(0, 0, 0, 12, 0, ONE, 0, 1), 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_m_ez", m_ez, 64'd0);
        check("arst_sat_cnt", sat_cnt, 64'd0);
        check("arst_s_ready", {63'b0, s_ready}, 64'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("arst_m_valid", {63'b0, m_valid}, 64'd0);
        end
        check("final_queue", sb_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
